// File: rtl/cordic_fix2float.sv
// -----------------------------------------------------------------------------
// cordic_fix2float
//
// Converts the CORDIC cosine core's signed Q2.20 output into an IEEE-754
// single-precision word. The magnitude is normalised one bit per cycle until
// its MSB sits at bit 21. Every Q2.20 value is exactly representable in
// float32, so the conversion is exact and needs no rounding stage.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   in_fix holds a value to convert
//   in_fix     in  22   signed Q2.20 (value = in_fix * 2^-20)
//   in_ready   out  1   block can accept an input (high only in IDLE)
//   out_valid  out  1   out_float holds a result (high only in DONE)
//   out_float  out 32   IEEE-754 single {sign, exp[7:0], frac[22:0]}
//   out_ready  in   1   consumer accepts out_float
// -----------------------------------------------------------------------------
module cordic_fix2float (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [21:0] in_fix,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_float,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [21:0] m_q, m_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] float_q, float_d;

    // Magnitude of a Q2.20 word. -2^21 negates to itself, which read as
    // unsigned is 0x200000: exactly the magnitude 2.0 we want.
    function automatic logic [21:0] abs_q220(input logic signed [21:0] v);
        logic signed [21:0] neg;
        neg = -v;
        return v[21] ? neg : v;
    endfunction

    // Packs a normalised magnitude (m[21] set) into the float word. The
    // hidden one is m[21]; the remaining 21 bits fill the top of the
    // 23-bit fraction field.
    function automatic logic [31:0] pack_float(input logic       s,
                                               input logic [7:0]  e,
                                               input logic [21:0] m);
        return {s, e, m[20:0], 2'b00};
    endfunction

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        float_d = float_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_fix[21];
                    m_d     = abs_q220(in_fix);
                    // m[21] carries weight 2^1, so an unshifted hit means
                    // exponent 1 + bias 127.
                    exp_d   = 8'd128;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (m_q == 22'd0) begin
                    // Two's complement has no negative zero, so sign is dropped.
                    float_d = 32'h0000_0000;
                    state_d = DONE;
                end else if (m_q[21]) begin
                    float_d = pack_float(sign_q, exp_q, m_q);
                    state_d = DONE;
                end else begin
                    m_d   = m_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= 22'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
            float_q <= 32'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            float_q <= float_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_float = float_q;

endmodule

// File: tb/tb_cordic_fix2float.sv
module tb_cordic_fix2float;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [21:0] in_fix = 22'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_float;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    cordic_fix2float dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_fix    (in_fix),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_float (out_float),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [21:0] fix;
        logic [31:0] flt;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: value = in_fix / 2^20. Find the highest set bit p of the
    // magnitude; value = 1.f * 2^(p-20), fraction is the bits below p aligned
    // to 23 bits. Latency = leading zeros in 22 bits + 1 = 22 - p.
    task automatic ref_float(input logic [21:0] v, output logic [31:0] f, output int lat);
        logic signed [21:0] s;
        int mag;
        int p;
        int e;
        int frac;
        s = v;
        mag = (s < 0) ? -int'(s) : int'(s);
        if (mag == 0) begin
            f = 32'd0;
            lat = 1;
        end else begin
            p = 0;
            while ((1 << (p + 1)) <= mag) p++;
            e = 127 + p - 20;
            frac = (mag - (1 << p)) << (23 - p);
            f = {(s < 0), 8'(e), 23'(frac)};
            lat = 22 - p;
        end
    endtask

    // Called at posedge+1. Feeds v, measures edges from accept until
    // out_valid, holds out_ready low for 'stall' cycles, then handshakes.
    // With 'noise' set, in_valid/in_fix are toggled while the block is busy.
    task automatic convert(input logic [21:0] v, input int stall, input bit noise,
                           output logic [31:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_fix   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            if (noise) begin
                in_valid = 1'($urandom % 2);
                in_fix   = 22'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        chk("result_valid", 32'(out_valid), 32'd1);
        res = out_float;
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_float", out_float, res);
            chk("stall_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_ready", 32'(in_ready), 32'd1);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_hold", out_float, res);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp_f;
        logic [21:0] v;
        int lat;
        int exp_lat;
        int seen;

        tbl[0] = '{22'h100000, 32'h3F800000, 2};
        tbl[1] = '{22'h0C0000, 32'h3F400000, 3};
        tbl[2] = '{22'h200000, 32'hC0000000, 1};
        tbl[3] = '{22'h3FFFFF, 32'hB5800000, 22};
        tbl[4] = '{22'h000000, 32'h00000000, 1};
        tbl[5] = '{22'h1FFFFF, 32'h3FFFFFF8, 2};
        tbl[6] = '{22'h300000, 32'hBF800000, 2};
        tbl[7] = '{22'h000001, 32'h35800000, 22};

        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_float", out_float, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors; zero input gets a 5-cycle backpressure stall
        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].fix, (tbl[i].fix == 22'd0) ? 5 : (i % 3), 1'b0, res, lat);
            chk($sformatf("tbl%0d_float", i), res, tbl[i].flt);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Busy input ignored: noise on in_valid/in_fix during a long conversion
        convert(22'h000001, 1, 1'b1, res, lat);
        chk("busy_float", res, 32'h35800000);
        chk("busy_lat", 32'(lat), 32'd22);

        // Asynchronous reset mid-NORM of 0x000001
        in_valid = 1'b1;
        in_fix   = 22'h000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("norm_in_ready", 32'(in_ready), 32'd0);
        chk("norm_out_valid", 32'(out_valid), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_float", out_float, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("arst_no_result", 32'(seen), 32'd0);
        chk("arst_idle", 32'(in_ready), 32'd1);

        // Random sweep against the reference model
        for (int n = 0; n < 1000; n++) begin
            v = 22'($urandom) >> $urandom_range(0, 21);
            if ($urandom % 2) v = -v;
            ref_float(v, exp_f, exp_lat);
            convert(v, $urandom_range(0, 3), 1'($urandom % 2), res, lat);
            chk($sformatf("rnd_float_%h", v), res, exp_f);
            chk($sformatf("rnd_lat_%h", v), 32'(lat), 32'(exp_lat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_fix2float.md
# cordic_fix2float

Sequential fixed-to-float converter directly downstream of the unrolled CORDIC cosine core. Takes the core's 22-bit signed Q2.20 `cos_out` and produces an IEEE-754 single-precision word for the floating-point datapath. It normalises iteratively, one bit per cycle, and uses a valid/ready handshake on both sides. Every Q2.20 value is exactly representable in float32, so the conversion is exact and has no rounding stage.

## Interface
- No parameters; widths fixed (22-bit input, 32-bit output).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `in_fix` holds a value to convert.
- in_fix  input  22  signed Q2.20 (value = in_fix × 2^-20, range [-2.0, 2.0 - 2^-20]).
- in_ready  output  1  block can accept an input; high only in IDLE.
- out_valid  output  1  `out_float` holds a result.
- out_float  output  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}.
- out_ready  input  1  consumer accepts `out_float`.

## Operation
- **States:** IDLE, NORM, DONE (2-bit register).
- **IDLE:**
  - in_ready = 1.
  - On in_valid && in_ready, register:
    - sign = in_fix[21];
    - m = |in_fix| as 22-bit unsigned (-2^21 maps to m = 0x200000);
    - exp = 8'd128.
  - Go to NORM.
- **NORM,** evaluated once per cycle in this priority:
  - m == 0: out_float = 32'h0000_0000 (no -0 exists in two's complement), go to DONE.
  - m[21] == 1: out_float = {sign, exp, m[20:0], 2'b00}, go to DONE.
  - Otherwise: m <= m << 1, exp <= exp - 1, stay in NORM.
- **DONE:**
  - out_valid = 1 and out_float is held stable.
  - On out_ready, go to IDLE.
  - out_float keeps its last value after the handshake; only out_valid drops.
- **Exponent range:** exp never goes below 107 (m = 1 needs 21 shifts). No denormal, Inf or NaN output is possible, and no overflow can occur (max |value| = 2.0 → exp 128, frac 0).
- **in_valid outside IDLE:** ignored. Upstream holds data until in_ready.
- **Reset (asynchronous, any state):** state = IDLE, out_valid = 0, out_float = 0, m = 0, exp = 0, sign = 0. Any in-flight conversion is discarded. in_ready = 1 once reset_n is high.

## Timing
- k = number of leading zeros of m within 22 bits (0..21); zero input is handled separately below.
- **Accept:** input is accepted at edge T. NORM occupies edges T+1 .. T+k+1.
- **Result:** out_valid rises after edge T+k+1, so latency is k+1 cycles (1 to 22).
- **Zero input:** out_valid rises after T+1.
- **Output hold:** out_valid stays high until the first edge with out_ready = 1. That edge returns the block to IDLE and in_ready rises after it.
- **Back-to-back:** the minimum spacing between accepts is k+3 cycles (accept, k+1 NORM cycles, DONE handshake cycle, return to IDLE). There is no overlap between conversions.
- **Combinational decodes of state (registered outputs, no input-to-output paths):**
  - in_ready = (state == IDLE);
  - out_valid = (state == DONE).

## Test plan
- **1.0 input:** reset, then in_fix = 0x100000 with out_ready = 1 → out_float = 0x3F800000; out_valid rises 2 cycles after accept.
- **Fractional value:** in_fix = 0x0C0000 (0.75) → 0x3F400000 after 3 cycles.
- **Extremes:**
  - in_fix = 0x200000 (-2.0) → 0xC0000000 after 1 cycle;
  - in_fix = 0x3FFFFF (-2^-20) → 0xB5800000 after 22 cycles.
- **Zero and backpressure:**
  - in_fix = 0 → out_float = 0x00000000 after 1 cycle.
  - Then hold out_ready = 0 for 5 cycles: out_valid and out_float must stay stable and in_ready must stay 0.
  - Raise out_ready: in_ready = 1 on the next cycle.
- **Reset and busy input:**
  - Assert reset_n = 0 asynchronously, mid-edge, during NORM of 0x000001 → out_valid = 0 and in_ready = 1 immediately. No result appears afterwards.
  - While a conversion is pending, toggle in_valid with a new value → it must be ignored.
- **Random sweep:** 1000 random in_fix values with random out_ready stalls → each result equals the float32 of in_fix/2^20, and each latency equals k+1.
